// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply / divide unit with HI/LO result registers.
//   Shift-add multiply and restoring divide, one bit per clock, WIDTH clocks
//   per operation. Supports multiply-accumulate/subtract, abort, and direct
//   HI/LO writes (mthi/mtlo).
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   start   launch the operation selected by op
//   op      000 mult, 001 multu, 010 div, 011 divu,
//           100 madd, 101 maddu, 110 msub, 111 msubu
//   a, b    operands (a also carries mthi/mtlo data)
//   we, sel direct write of a into LO (sel=1) or HI (sel=0) while idle
//   cancel  abort the in-flight operation; HI/LO keep their values
//   busy    operation in flight
//   done    one-cycle pulse when HI/LO were updated by a completed operation
//   HI, LO  high product / remainder, low product / quotient
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we,
    input  logic             sel,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_r;
    logic               neg_r, sgn_a_r, div0_r;
    logic [WIDTH-1:0]   opnd, q, a_raw;
    logic [WIDTH:0]     rem;
    logic [2*WIDTH-1:0] cap;

    // Magnitude of a two's-complement operand when treated as signed.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                             input logic is_signed);
        logic signed [WIDTH-1:0] r;
        r = v;
        if (is_signed && v[WIDTH-1]) r = -v;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    logic accept, finish, is_signed, sa, sb, is_div_r;
    logic [WIDTH-1:0] ma, mb;

    assign busy      = (state == RUN);
    assign accept    = (state == IDLE) && start && !cancel;
    assign finish    = (state == RUN) && !cancel && (cnt == CW'(1));
    assign is_signed = !op[0];
    assign sa        = is_signed && a[WIDTH-1];
    assign sb        = is_signed && b[WIDTH-1];
    assign ma        = mag(a, is_signed);
    assign mb        = mag(b, is_signed);
    assign is_div_r  = !op_r[2] && op_r[1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (cancel || cnt == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // One iteration: multiply shifts {rem,q} right after a conditional add;
    // divide shifts {rem,q} left and subtracts the divisor when it fits.
    logic [WIDTH:0]   add_sum, shifted, rem_nxt;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] q_nxt;

    always_comb begin
        add_sum = rem + (q[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shifted = {rem[WIDTH-1:0], q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd};
        rem_nxt = {1'b0, add_sum[WIDTH:1]};
        q_nxt   = {add_sum[0], q[WIDTH-1:1]};
        if (is_div_r) begin
            if (!diff[WIDTH+1]) begin
                rem_nxt = diff[WIDTH:0];
                q_nxt   = {q[WIDTH-2:0], 1'b1};
            end else begin
                rem_nxt = shifted;
                q_nxt   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Final result formed from the last iteration's outputs.
    logic [2*WIDTH-1:0] prod, res;

    always_comb begin
        prod = neg_2w({rem_nxt[WIDTH-1:0], q_nxt}, neg_r);
        res  = prod;
        if (op_r[2]) begin
            res = op_r[1] ? (cap - prod) : (cap + prod);
        end else if (op_r[1]) begin
            if (div0_r) res = {a_raw, {WIDTH{1'b1}}};
            else        res = {neg_w(rem_nxt[WIDTH-1:0], sgn_a_r), neg_w(q_nxt, neg_r)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            op_r    <= '0;
            neg_r   <= 1'b0;
            sgn_a_r <= 1'b0;
            div0_r  <= 1'b0;
            opnd    <= '0;
            q       <= '0;
            a_raw   <= '0;
            rem     <= '0;
            cap     <= '0;
            done    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                cnt     <= CW'(WIDTH);
                op_r    <= op;
                neg_r   <= sa ^ sb;
                sgn_a_r <= sa;
                div0_r  <= (b == '0);
                a_raw   <= a;
                rem     <= '0;
                cap     <= {HI, LO};
                if (!op[2] && op[1]) begin
                    opnd <= mb;
                    q    <= ma;
                end else begin
                    opnd <= ma;
                    q    <= mb;
                end
            end else if (state == RUN) begin
                if (cancel) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt - CW'(1);
                    rem <= rem_nxt;
                    q   <= q_nxt;
                    if (finish) {HI, LO} <= res;
                end
            end else if (we && !start) begin
                if (sel) LO <= a;
                else     HI <= a;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed and randomized bench for muldiv_iter (WIDTH=32)
// with a plain-arithmetic reference model of the HI/LO results.
module tb_muldiv_iter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         we = 1'b0;
    logic         sel = 1'b0;
    logic         cancel = 1'b0;
    logic         busy, done;
    logic [W-1:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .we(we), .sel(sel), .cancel(cancel), .busy(busy), .done(done),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: signed ops via 64-bit signed arithmetic, unsigned via
    // zero-extended 64-bit arithmetic; SV '/' and '%' truncate toward zero
    // and give the remainder the dividend's sign.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic [W-1:0] hi,
                                          input logic [W-1:0] lo);
        longint      sx, sy, sq, sr;
        logic [63:0] sp, up, acc, r;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        sp  = sx * sy;
        up  = {32'b0, x} * {32'b0, y};
        acc = {hi, lo};
        case (o)
            3'd0: r = sp;
            3'd1: r = up;
            3'd2, 3'd3: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else if (o == 3'd2) begin
                    sq = sx / sy;
                    sr = sx % sy;
                    r  = {sr[31:0], sq[31:0]};
                end else r = {x % y, x / y};
            end
            3'd4: r = acc + sp;
            3'd5: r = acc + up;
            3'd6: r = acc - sp;
            default: r = acc - up;
        endcase
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [63:0] exp);
        logic lat_ok;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        check({tag, "_busy_accept"}, {63'b0, busy}, 64'd1);
        lat_ok = 1'b1;
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            start = 1'b0; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            if (i < W && (busy !== 1'b1 || done !== 1'b0)) lat_ok = 1'b0;
        end
        check({tag, "_latency"}, {63'b0, lat_ok}, 64'd1);
        check({tag, "_busy_end"}, {63'b0, busy}, 64'd0);
        check({tag, "_done"}, {63'b0, done}, 64'd1);
        check({tag, "_hilo"}, {HI, LO}, exp);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic mt(input logic s, input logic [W-1:0] d);
        @(negedge clk);
        we = 1'b1; sel = s; a = d;
        @(negedge clk);
        we = 1'b0;
        if (s) m_lo = d;
        else   m_hi = d;
    endtask

    initial begin
        logic        flag;
        logic [2:0]  ro;
        logic [W-1:0] ra, rb;
        int          pick;

        #1;
        check("reset_state", {HI, LO, 30'b0, busy, done}, 96'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu", 3'd3, 32'd7, 32'd2, 64'h0000_0001_0000_0003);
        run_op("div_min", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("divu_zero", 3'd3, 32'h1234, 32'd0, 64'h0000_1234_FFFF_FFFF);

        mt(1'b1, 32'd5);
        mt(1'b0, 32'd0);
        #1;
        check("mt_write", {HI, LO}, 64'h0000_0000_0000_0005);
        check("mt_no_done", {63'b0, done}, 64'd0);
        run_op("maddu", 3'd5, 32'hFFFF_FFFF, 32'd2, 64'h0000_0002_0000_0003);
        mt(1'b1, 32'd0);
        mt(1'b0, 32'd0);
        run_op("msub", 3'd6, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Cancel mid-multiply, with an ignored write and restart first.
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd1234; b = 32'd5678;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        we = 1'b1; sel = 1'b0; a = 32'hAA; start = 1'b1;
        @(posedge clk); #1;
        check("busy_ignore_start", {63'b0, busy}, 64'd1);
        check("we_ignored_busy", {32'b0, HI}, {32'b0, m_hi});
        @(negedge clk);
        we = 1'b0; start = 1'b0; cancel = 1'b1;
        @(posedge clk); #1;
        check("cancel_busy", {63'b0, busy}, 64'd0);
        check("cancel_hilo", {HI, LO}, {m_hi, m_lo});
        @(negedge clk);
        cancel = 1'b0;
        flag = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) flag = 1'b1;
        end
        check("cancel_no_done", {63'b0, flag}, 64'd0);
        check("cancel_hilo_after", {HI, LO}, {m_hi, m_lo});

        // Cancel together with start while idle: start is ignored.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        check("idle_cancel_start", {63'b0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;

        // Asynchronous reset between edges during a divide.
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset", {HI, LO, 30'b0, busy, done}, 96'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        check("post_reset_idle", {63'b0, busy}, 64'd0);
        run_op("mult_after_reset", 3'd0, 32'd2, 32'd3, 64'd6);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            ro   = 3'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = $urandom;
            pick = $urandom_range(0, 9);
            if (pick == 0) rb = '0;
            else if (pick == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (pick == 2) rb = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0) mt(1'($urandom_range(0, 1)), $urandom);
            run_op("rand", ro, ra, rb, model(ro, ra, rb, m_hi, m_lo));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
